// File: rtl/uart_wb_master.sv
// UART-to-Wishbone bridge: 8N1 commands become single Wishbone cycles.
// Ports: clock, reset (sync, high), uart_rx/uart_tx, wb_* master side.
// Optional: UART_WB_MASTER_TIMEOUT_EN bounds the wait for wb_ack_i.
module uart_wb_master #(
  parameter int CLKS_PER_BIT   = 104,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic [31:0] wb_addr_o,
  output logic [31:0] wb_data_o,
  output logic        wb_cyc_o,
  output logic        wb_strobe_o,
  output logic        wb_we_o,
  input  logic [31:0] wb_data_i,
  input  logic        wb_ack_i
);

  // One width shared by every cycle counter in the block.
  localparam int MAXC =
    (CLKS_PER_BIT > TIMEOUT_CYCLES) ? CLKS_PER_BIT : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] S_CMD   = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_WDATA = 3'd2;
  localparam logic [2:0] S_BUS   = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  logic          rx_s1, rx_s2, rx_prev;
  logic [1:0]    rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_s1    <= uart_rx;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_valid <= 1'b0;
      unique case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == CW'(CLKS_PER_BIT / 2 - 1)) begin
            rx_cnt <= '0;
            // High at mid-start is a glitch, not a frame.
            if (rx_s2) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_state <= RX_DATA;
              rx_bit   <= '0;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == CW'(CLKS_PER_BIT - 1)) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else rx_bit <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == CW'(CLKS_PER_BIT - 1)) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            rx_valid <= rx_s2;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  logic          tx_busy;
  logic [9:0]    tx_frame;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic          tx_go;
  logic [7:0]    tx_byte;

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_busy  <= 1'b0;
      tx_frame <= '1;
      tx_cnt   <= '0;
      tx_bit   <= '0;
    end else if (!tx_busy) begin
      if (tx_go) begin
        tx_frame <= {1'b1, tx_byte, 1'b0};
        tx_busy  <= 1'b1;
        tx_cnt   <= '0;
        tx_bit   <= '0;
      end
    end else if (tx_cnt == CW'(CLKS_PER_BIT - 1)) begin
      tx_cnt <= '0;
      if (tx_bit == 4'd9) begin
        tx_busy <= 1'b0;
      end else begin
        tx_frame <= {1'b1, tx_frame[9:1]};
        tx_bit   <= tx_bit + 4'd1;
      end
    end else begin
      tx_cnt <= tx_cnt + 1'b1;
    end
  end

  assign uart_tx = tx_busy ? tx_frame[0] : 1'b1;

  logic [2:0]  state;
  logic        is_write;
  logic [1:0]  byte_cnt;
  logic [31:0] resp_shift;
  logic [2:0]  resp_left;

  // Response bytes leave MSB first, one per idle transmitter.
  assign tx_byte = resp_shift[31:24];
  assign tx_go   = (state == S_RESP) && !tx_busy &&
                   (resp_left != 3'd0);

`ifdef UART_WB_MASTER_TIMEOUT_EN
  logic [CW-1:0] to_cnt;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_CMD;
      is_write    <= 1'b0;
      byte_cnt    <= '0;
      wb_addr_o   <= '0;
      wb_data_o   <= '0;
      wb_cyc_o    <= 1'b0;
      wb_strobe_o <= 1'b0;
      wb_we_o     <= 1'b0;
      resp_shift  <= '0;
      resp_left   <= '0;
`ifdef UART_WB_MASTER_TIMEOUT_EN
      to_cnt      <= '0;
`endif
    end else begin
      unique case (state)
        S_CMD: begin
          if (rx_valid) begin
            byte_cnt <= '0;
            if (rx_shift == 8'h01) begin
              is_write <= 1'b0;
              state    <= S_ADDR;
            end else if (rx_shift == 8'h02) begin
              is_write <= 1'b1;
              state    <= S_ADDR;
            end
          end
        end
        S_ADDR: begin
          if (rx_valid) begin
            wb_addr_o <= {wb_addr_o[23:0], rx_shift};
            byte_cnt  <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (is_write) begin
                state <= S_WDATA;
              end else begin
                state       <= S_BUS;
                wb_cyc_o    <= 1'b1;
                wb_strobe_o <= 1'b1;
              end
            end
          end
        end
        S_WDATA: begin
          if (rx_valid) begin
            wb_data_o <= {wb_data_o[23:0], rx_shift};
            byte_cnt  <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state       <= S_BUS;
              wb_cyc_o    <= 1'b1;
              wb_strobe_o <= 1'b1;
              wb_we_o     <= 1'b1;
            end
          end
        end
        S_BUS: begin
          if (wb_ack_i) begin
            wb_cyc_o    <= 1'b0;
            wb_strobe_o <= 1'b0;
            wb_we_o     <= 1'b0;
            state       <= S_RESP;
            if (is_write) begin
              resp_shift <= {8'hA5, 24'h0};
              resp_left  <= 3'd1;
            end else begin
              resp_shift <= wb_data_i;
              resp_left  <= 3'd4;
            end
`ifdef UART_WB_MASTER_TIMEOUT_EN
            to_cnt <= '0;
          end else if (to_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            wb_cyc_o    <= 1'b0;
            wb_strobe_o <= 1'b0;
            wb_we_o     <= 1'b0;
            state       <= S_RESP;
            resp_shift  <= {8'hEE, 24'h0};
            resp_left   <= 3'd1;
            to_cnt      <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
`endif
          end
        end
        S_RESP: begin
          if (tx_go) begin
            resp_shift <= {resp_shift[23:0], 8'h00};
            resp_left  <= resp_left - 3'd1;
          end else if (resp_left == 3'd0 && !tx_busy) begin
            state <= S_CMD;
          end
        end
        default: state <= S_CMD;
      endcase
    end
  end

endmodule

// File: doc/uart_wb_master.md
UART_WB_MASTER -- requirements
Module: uart_wb_master

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104, meaning clock cycles per UART bit (12 MHz / 115200).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning maximum cycles to wait for wb_ack_i.
REQ-003 SHALL have port clock  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port uart_rx  input  1  asynchronous serial input, 8N1, idle high.
REQ-006 SHALL have port uart_tx  output  1  serial output, 8N1, idle high.
REQ-007 SHALL have port wb_addr_o  output  32  Wishbone address, driving the system slave wb_addr_i.
REQ-008 SHALL have port wb_data_o  output  32  Wishbone write data, driving the slave wb_data_i.
REQ-009 SHALL have ports wb_cyc_o, wb_strobe_o, wb_we_o  output  1 each  Wishbone cycle, strobe and write-enable.
REQ-010 SHALL have port wb_data_i  input  32  Wishbone read data from the slave wb_data_o.
REQ-011 SHALL have port wb_ack_i  input  1  Wishbone acknowledge from the slave wb_ack_o.

Function
REQ-012 Receiver SHALL synchronise uart_rx through two flops, detect the falling start edge, and sample each bit at mid-bit (CLKS_PER_BIT/2 after the edge, then every CLKS_PER_BIT).
REQ-013 Receiver SHALL shift in 8 bits LSB first; a stop bit sampled low SHALL discard the byte (framing error) with no state change.
REQ-014 A start bit sampled high at mid-bit SHALL be treated as a glitch and the receiver SHALL return to idle.
REQ-015 Transmitter SHALL emit start(0), 8 data bits LSB first, stop(1), each CLKS_PER_BIT cycles long; uart_tx SHALL be 1 when idle.
REQ-016 Control FSM states: CMD, ADDR, WDATA, BUS, RESP.
REQ-017 CMD: byte 0x01 = read and byte 0x02 = write go to ADDR; any other byte SHALL be dropped, staying in CMD.
REQ-018 ADDR SHALL collect 4 bytes big-endian into wb_addr_o; then go to WDATA for write, or to BUS for read.
REQ-019 WDATA SHALL collect 4 bytes big-endian into wb_data_o, then go to BUS.
REQ-020 BUS SHALL assert wb_cyc_o and wb_strobe_o together (wb_we_o=1 for write) until the first cycle wb_ack_i=1, and deassert all three the next cycle.
REQ-021 On ack of a read, wb_data_i SHALL be latched on the ack cycle; RESP SHALL send 4 bytes big-endian.
REQ-022 On ack of a write, RESP SHALL send the single byte 0xA5.
REQ-023 After the last response byte's stop bit completes, the FSM SHALL return to CMD.
REQ-024 Bytes received during BUS or RESP SHALL be discarded.
REQ-025 wb_ack_i asserted outside BUS SHALL be ignored.
REQ-026 wb_addr_o and wb_data_o SHALL hold their values after the cycle ends, until the next command overwrites them.

Reset
REQ-027 Reset SHALL force: FSM=CMD, uart_tx=1, wb_cyc_o=wb_strobe_o=wb_we_o=0, wb_addr_o=wb_data_o=0, receiver and transmitter idle, all counters 0.
REQ-028 Reset asserted mid-frame or mid-bus-cycle SHALL abort immediately; the partial byte or command SHALL be lost.

Configuration
REQ-029 With macro UART_WB_MASTER_TIMEOUT_EN defined, BUS SHALL count cycles; if no ack arrives within TIMEOUT_CYCLES cycles, the FSM SHALL drop cyc/strobe/we, send the single byte 0xEE, and return to CMD.
REQ-030 Without UART_WB_MASTER_TIMEOUT_EN, BUS SHALL wait for wb_ack_i indefinitely, and no timeout counter SHALL be synthesised.

Verification
REQ-031 Bench SHALL cover write: send 02 00 00 00 10 DE AD BE EF, slave acks after 3 cycles -> one cycle seen with addr=0x00000010, data=0xDEADBEEF, we=1; tx byte 0xA5.
REQ-032 Bench SHALL cover read: send 01 00 00 00 04, slave returns 0x12345678 -> we=0; tx bytes 12 34 56 78.
REQ-033 Bench SHALL cover bad command: send 0x7F then a valid read -> 0x7F ignored, read completes normally.
REQ-034 Bench SHALL cover framing error: byte sent with stop bit 0 inside ADDR -> byte dropped; ADDR still expects the same remaining byte count.
REQ-035 Bench SHALL cover reset: reset pulsed during BUS -> cyc/strobe drop the next cycle, uart_tx=1, a new command is accepted.
REQ-036 Bench SHALL cover timeout (macro defined, TIMEOUT_CYCLES=16): slave never acks -> cyc deasserted after 16 cycles, tx byte 0xEE.
